fft_out_reorder: RTL and testbench
==================================

# fft_out_reorder

Output-side companion to the FFT `top` block. It captures one 64-point frame of complex results from the FFT output stream (`data_out`/`is_out`) into an internal frame buffer. It then replays the frame to a downstream consumer over a valid/ready handshake, optionally converting bit-reversed FFT output order to natural frequency order. It sits between FFT `top` and any result sink: file dumper, UART, or magnitude stage.

## Interface
- `N`, 64, frame length in complex samples; power of two, 4..1024
- `LOG2N`, 6, log2(N); index and counter width
- `DW`, 32, sample width; `{re[DW/2-1:0], im[DW/2-1:0]}`, two's complement
- `clk` in 1, single clock; all state updates on rising edge
- `rst` in 1, reset, synchronous and active-high
- `in_data` in DW, FFT result word; connect to FFT `data_out`
- `in_valid` in 1, one result word present this cycle; connect to FFT `is_out`; no backpressure toward the FFT
- `out_data` out DW, reordered sample
- `out_valid` out 1, `out_data` is valid
- `out_ready` in 1, consumer accepts `out_data` this cycle
- `out_last` out 1, high with the final sample (index N-1) of a frame
- `out_index` out LOG2N, natural-order frequency bin of `out_data`
- `overflow` out 1, sticky; input word arrived while the buffer was draining

## Operation
- Two states:
  - FILL (reset state): each cycle with `in_valid`=1 writes `in_data` to `mem[wr_cnt]`, then `wr_cnt`++.
  - When the write with `wr_cnt`=N-1 occurs, `wr_cnt` wraps to 0 and the state moves to DRAIN.
- DRAIN:
  - `out_valid`=1 throughout.
  - `out_index`=`rd_cnt`; `out_data`=`mem[rd_addr]`, where `rd_addr` = `bitrev(rd_cnt)` or `rd_cnt` (see Configuration).
  - Transfer occurs when `out_valid`&`out_ready`; on each transfer `rd_cnt`++.
  - `out_last` = DRAIN & (`rd_cnt`==N-1).
  - The transfer with `out_last`=1 wraps `rd_cnt` to 0 and returns the state to FILL.
- Input during DRAIN, including the final drain cycle, is dropped and sets `overflow`=1. It stays 1 until `rst`.
- While `out_valid`=1 and `out_ready`=0, `out_data`, `out_index` and `out_last` hold stable. `out_valid` never drops without a transfer.
- Data is passed unmodified. No scaling or rounding.

## Timing
- Reset values: state=FILL, `wr_cnt`=0, `rd_cnt`=0, `out_valid`=0, `out_last`=0, `out_index`=0, `overflow`=0. `out_data` is don't-care but is driven from `mem[0]`.
- Buffer contents are not cleared by reset.
- `rst` mid-frame discards any partial fill or drain. The next `in_valid` is written to index 0.
- Latency: `out_valid` rises the cycle after the N-th input write.
- With `out_ready` held at 1, a frame drains in exactly N cycles. FILL is re-entered on cycle N+1 after drain start.
- `out_data` is read combinationally from the array at registered `rd_addr` (distributed RAM). There is no read-pipeline bubble between consecutive transfers.
- Back-to-back frames: the FFT must not assert `in_valid` during DRAIN. A violation is reported via `overflow`, not stalled.

## Configuration
- `FFT_REORDER_BITREV_EN` defined: `rd_addr` = bit-reversal of `rd_cnt` over LOG2N bits. The input is taken as bit-reversed order and the output is in natural order; e.g. N=64, `rd_cnt`=1 reads `mem[32]`.
- Not defined: `rd_addr`=`rd_cnt`. The frame is replayed in arrival order, and `out_index` then equals arrival position.

## Structure
- Shared package `fft_pkg`: `N`/`LOG2N` defaults, `DW`, typedef `cplx_t` (packed struct `re`, `im`), state enum `reorder_state_e {FILL, DRAIN}`, function `bitrev(idx)`.
- One natural sub-module: `fft_frame_ram` (N×DW, one synchronous write port, one asynchronous read port).
- Counters, FSM and handshake live in `fft_out_reorder`.

## Test plan
- Reset then 64 consecutive `in_valid` words with value i at arrival i, `out_ready`=1, macro defined -> `out_valid` rises the cycle after word 63. Output k carries `bitrev6(k)`: k=1 gives 32, k=2 gives 16, k=63 gives 63. `out_last` is high only at k=63.
- Same frame, macro undefined -> output k = k, `out_index`=k, 64 consecutive cycles.
- Random `out_ready` (≈50%) -> the sequence is identical to the previous cases. `out_data`/`out_index` are stable across every stalled cycle, and exactly 64 transfers occur.
- `in_valid` pulsed with gaps (one word every 3 cycles) -> DRAIN is entered only after the 64th word. The word count is unaffected by the gaps.
- `in_valid`=1 during DRAIN (word 0xDEADBEEF) -> the word is not present in the next frame, and `overflow`=1 persists until `rst`.
- `rst` asserted after 40 input words, then a fresh 64-word frame -> the first output corresponds to the new frame's word at address 0, `out_valid`=0 during the reset cycle, and `overflow`=0.

Source files
------------

// File: rtl/fft_pkg.sv
// fft_pkg: types and helpers shared by the FFT output-side blocks.
//
// Contents:
//   FFT_N, FFT_LOG2N, FFT_DW  default frame length, index width and sample width
//   BITREV_MAX                widest index bitrev() can reverse (N up to 1024)
//   cplx_t                    packed complex sample {re, im}, two's complement
//   reorder_state_e           FILL / DRAIN states of the output reorder buffer
//   bitrev(idx, bits)         reverses the low 'bits' bits of idx
package fft_pkg;

  localparam int FFT_N      = 64;
  localparam int FFT_LOG2N  = 6;
  localparam int FFT_DW     = 32;
  localparam int BITREV_MAX = 10;

  typedef struct packed {
    logic signed [FFT_DW/2-1:0] re;
    logic signed [FFT_DW/2-1:0] im;
  } cplx_t;

  typedef enum logic [0:0] {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } reorder_state_e;

  // Reverse all BITREV_MAX bits, then shift right so that only the reversed
  // low 'bits' bits remain. The caller guarantees idx has zeros above 'bits'.
  function automatic logic [BITREV_MAX-1:0] bitrev(input logic [BITREV_MAX-1:0] idx,
                                                   input int unsigned bits);
    logic [BITREV_MAX-1:0] full;
    full = {<<{idx}};
    return full >> (BITREV_MAX - bits);
  endfunction

endpackage

// File: rtl/fft_out_reorder_if.sv
// fft_out_reorder_if: signal bundle of the FFT output reorder buffer.
//
// Handshake rules:
//   in_data/in_valid   : FFT result stream, no backpressure. A word is taken on
//                        every rising edge where in_valid=1.
//   out_data/out_valid/out_ready : strict valid/ready. A transfer happens on a
//                        rising edge where out_valid=1 and out_ready=1. While
//                        out_valid=1 and out_ready=0, out_data, out_index and
//                        out_last hold, and out_valid does not drop.
//   out_last  : final sample of a frame, out_index : natural-order bin.
//   overflow  : sticky, input arrived while the buffer was draining.
//   state     : current FSM state (FILL=0, DRAIN=1) for observation.
//
// Modports: master = the reorder block, slave = the FFT/consumer side.
interface fft_out_reorder_if
  import fft_pkg::*;
#(
  parameter int DW    = FFT_DW,
  parameter int LOG2N = FFT_LOG2N
);
  logic [DW-1:0]    in_data;
  logic             in_valid;
  logic [DW-1:0]    out_data;
  logic             out_valid;
  logic             out_ready;
  logic             out_last;
  logic [LOG2N-1:0] out_index;
  logic             overflow;
  logic [0:0]       state;

  modport master (
    input  in_data, in_valid, out_ready,
    output out_data, out_valid, out_last, out_index, overflow, state
  );

  modport slave (
    output in_data, in_valid, out_ready,
    input  out_data, out_valid, out_last, out_index, overflow, state
  );
endinterface

// File: rtl/fft_frame_ram.sv
// fft_frame_ram: N x DW frame buffer, one synchronous write port and one
// asynchronous read port (maps to distributed RAM). Contents are not reset.
//
// Ports:
//   clk    in           write clock
//   we     in           write enable
//   waddr  in  LOG2N    write address
//   wdata  in  DW       write data
//   raddr  in  LOG2N    read address
//   rdata  out DW       mem[raddr], combinational
module fft_frame_ram
  import fft_pkg::*;
#(
  parameter int N     = FFT_N,
  parameter int LOG2N = FFT_LOG2N,
  parameter int DW    = FFT_DW
) (
  input  logic             clk,
  input  logic             we,
  input  logic [LOG2N-1:0] waddr,
  input  logic [DW-1:0]    wdata,
  input  logic [LOG2N-1:0] raddr,
  output logic [DW-1:0]    rdata
);

  logic [DW-1:0] mem [N];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fft_out_reorder.sv
// fft_out_reorder: captures one N-point frame from the FFT output stream and
// replays it to a downstream consumer over valid/ready.
//
// Build option:
//   FFT_REORDER_BITREV_EN  defined   : frame is read at bitrev(rd_cnt), turning
//                                      bit-reversed FFT order into natural order.
//                          undefined : frame is replayed in arrival order.
//
// Ports:
//   clk   in   single clock, rising edge
//   rst   in   synchronous, active-high reset
//   bus   fft_out_reorder_if.master  (in_data/in_valid from the FFT,
//         out_data/out_valid/out_ready/out_last/out_index to the consumer,
//         sticky overflow, FSM state for observation)
//
// FILL writes each in_valid word to mem[wr_cnt]; the N-th write moves to
// DRAIN. DRAIN holds out_valid high and advances rd_cnt on each transfer; the
// transfer with out_last returns to FILL. Input seen during DRAIN is dropped
// and flags overflow.
module fft_out_reorder
  import fft_pkg::*;
#(
  parameter int N     = FFT_N,
  parameter int LOG2N = FFT_LOG2N,
  parameter int DW    = FFT_DW
) (
  input  logic               clk,
  input  logic               rst,
  fft_out_reorder_if.master  bus
);

  localparam logic [0:0]       ST_FILL  = 1'b0;
  localparam logic [0:0]       ST_DRAIN = 1'b1;
  localparam logic [LOG2N-1:0] LAST_IDX = LOG2N'(N - 1);

  logic [0:0]       state;
  logic [LOG2N-1:0] wr_cnt;
  logic [LOG2N-1:0] rd_cnt;
  logic [LOG2N-1:0] rd_addr;
  logic [LOG2N-1:0] rd_cnt_next;
  logic [LOG2N-1:0] rd_addr_next;
  logic             overflow_q;
  logic             wr_en;
  logic [DW-1:0]    rd_data;

  assign wr_en       = bus.in_valid && (state == ST_FILL);
  assign rd_cnt_next = rd_cnt + 1'b1;

  // rd_addr is registered together with rd_cnt so the RAM read is a plain
  // register-to-array path with no reversal logic in front of it. N is a power
  // of two, so the counter wraps to 0 (and bitrev(0)=0) on the last transfer.
`ifdef FFT_REORDER_BITREV_EN
  assign rd_addr_next = LOG2N'(bitrev(BITREV_MAX'(rd_cnt_next), LOG2N));
`else
  assign rd_addr_next = rd_cnt_next;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_FILL;
      wr_cnt     <= '0;
      rd_cnt     <= '0;
      rd_addr    <= '0;
      overflow_q <= 1'b0;
    end else if (state == ST_FILL) begin
      if (bus.in_valid) begin
        wr_cnt <= wr_cnt + 1'b1;
        if (wr_cnt == LAST_IDX) begin
          state <= ST_DRAIN;
        end
      end
    end else begin
      // No backpressure toward the FFT: a word here is lost, so record it.
      if (bus.in_valid) begin
        overflow_q <= 1'b1;
      end
      if (bus.out_ready) begin
        rd_cnt  <= rd_cnt_next;
        rd_addr <= rd_addr_next;
        if (rd_cnt == LAST_IDX) begin
          state <= ST_FILL;
        end
      end
    end
  end

  fft_frame_ram #(
    .N     (N),
    .LOG2N (LOG2N),
    .DW    (DW)
  ) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_cnt),
    .wdata (bus.in_data),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  // Outputs depend only on registered state, so they hold during stalls.
  assign bus.out_valid = (state == ST_DRAIN);
  assign bus.out_last  = (state == ST_DRAIN) && (rd_cnt == LAST_IDX);
  assign bus.out_index = rd_cnt;
  assign bus.out_data  = rd_data;
  assign bus.overflow  = overflow_q;
  assign bus.state     = state;

endmodule

// File: tb/tb_fft_out_reorder.sv
// tb_fft_out_reorder: directed/randomized bench for fft_out_reorder.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// Expected output order comes from a frame array and the reorder rule
// (bit-reversed index when FFT_REORDER_BITREV_EN is defined, arrival order
// otherwise).
module tb_fft_out_reorder;
  localparam int N     = 64;
  localparam int LOG2N = 6;
  localparam int DW    = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fft_out_reorder_if #(.DW(DW), .LOG2N(LOG2N)) bus ();

  fft_out_reorder #(
    .N     (N),
    .LOG2N (LOG2N),
    .DW    (DW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] frame [N];

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Position in the captured frame that output k must come from.
  function automatic int ref_addr(input int k);
    int r;
    r = k;
`ifdef FFT_REORDER_BITREV_EN
    r = 0;
    for (int b = 0; b < LOG2N; b++) r = r * 2 + ((k >> b) & 1);
`endif
    return r;
  endfunction

  // ---------------- driver tasks ----------------
  // Presents 'count' words, leaving 'gap' idle cycles between words. Ends with
  // the last word still driven, so the caller's next falling edge is the first
  // one after that word has been written.
  task automatic fill_frame(input int count, input int gap, input bit rnd);
    logic [DW-1:0] w;
    for (int i = 0; i < count; i++) begin
      @(negedge clk);
      check("fill_valid_low", DW'(bus.out_valid), '0);
      w = rnd ? DW'($urandom) : DW'(i);
      frame[i]     = w;
      bus.in_valid = 1'b1;
      bus.in_data  = w;
      if (i < count - 1) begin
        for (int g = 0; g < gap; g++) begin
          @(negedge clk);
          bus.in_valid = 1'b0;
          check("gap_valid_low", DW'(bus.out_valid), '0);
        end
      end
    end
  endtask

  // Consumes a whole frame with out_ready high ready_pct% of the time.
  // inject_last drives 0xDEADBEEF on the final drain cycle.
  task automatic drain_frame(input int ready_pct, input bit inject_last);
    int            k = 0;
    int            cycles = 0;
    bit            first = 1'b1;
    bit            stalled = 1'b0;
    bit            r;
    logic [DW-1:0] held_d = '0;
    logic [DW-1:0] held_i = '0;
    logic [DW-1:0] held_l = '0;
    exp_q.delete();
    for (int j = 0; j < N; j++) exp_q.push_back(frame[ref_addr(j)]);
    while (k < N && cycles < 4 * N + 50) begin
      @(negedge clk);
      cycles++;
      bus.in_valid = 1'b0;
      if (first) begin
        check("latency_valid", DW'(bus.out_valid), DW'(1));
        first = 1'b0;
      end
      if (stalled) begin
        check("stall_valid", DW'(bus.out_valid), DW'(1));
        check("stall_data",  bus.out_data, held_d);
        check("stall_index", DW'(bus.out_index), held_i);
        check("stall_last",  DW'(bus.out_last), held_l);
      end
      r = ($urandom_range(99) < ready_pct);
      if (inject_last && k == N - 1) begin
        r            = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 32'hDEADBEEF;
      end
      bus.out_ready = r;
      if (bus.out_valid && r) begin
        check("data",  bus.out_data, exp_q.pop_front());
        check("index", DW'(bus.out_index), DW'(k));
        check("last",  DW'(bus.out_last), DW'(k == N - 1));
        k++;
        stalled = 1'b0;
      end else if (bus.out_valid) begin
        stalled = 1'b1;
        held_d  = bus.out_data;
        held_i  = DW'(bus.out_index);
        held_l  = DW'(bus.out_last);
      end else begin
        check("drain_valid", DW'(bus.out_valid), DW'(1));
      end
    end
    if (k < N) check("drain_transfers", DW'(k), DW'(N));
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    check("after_drain_valid_low", DW'(bus.out_valid), '0);
    check("after_drain_state_fill", DW'(bus.state), '0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_valid",    DW'(bus.out_valid), '0);
    check("reset_last",     DW'(bus.out_last), '0);
    check("reset_index",    DW'(bus.out_index), '0);
    check("reset_overflow", DW'(bus.overflow), '0);
    check("reset_state",    DW'(bus.state), '0);
    rst = 1'b0;

    // Ramp frame, consumer always ready.
    fill_frame(N, 0, 1'b0);
    drain_frame(100, 1'b0);
    check("overflow_clear_1", DW'(bus.overflow), '0);

    // Ramp frame, random backpressure.
    fill_frame(N, 0, 1'b0);
    drain_frame(50, 1'b0);

    // Random frame with a word every third cycle.
    fill_frame(N, 2, 1'b1);
    drain_frame(50, 1'b0);
    check("overflow_clear_2", DW'(bus.overflow), '0);

    // Word pushed on the final drain cycle must be dropped and flagged.
    fill_frame(N, 0, 1'b1);
    drain_frame(100, 1'b1);
    check("overflow_set", DW'(bus.overflow), DW'(1));
    fill_frame(N, 0, 1'b1);
    drain_frame(70, 1'b0);
    check("overflow_sticky", DW'(bus.overflow), DW'(1));

    // Reset mid-fill, then a fresh frame.
    fill_frame(40, 0, 1'b1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst          = 1'b1;
    @(negedge clk);
    check("midreset_valid",    DW'(bus.out_valid), '0);
    check("midreset_overflow", DW'(bus.overflow), '0);
    check("midreset_index",    DW'(bus.out_index), '0);
    rst = 1'b0;
    fill_frame(N, 0, 1'b1);
    drain_frame(50, 1'b0);
    check("overflow_after_reset", DW'(bus.overflow), '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
